// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic slice with a one-entry skid buffer and valid/ready handshake.
// Define LOGIC_EXT_OPS_EN to add NAND, XNOR, pass-B and constant-zero opcodes.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_zero,
  output logic              out_illegal
);

  // Returns {illegal, data}; unsupported codes yield data 0 with illegal set.
  function automatic logic [WIDTH:0] f_logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [CTRL_W-1:0] op);
    logic [WIDTH-1:0] d;
    logic             ill;
    d   = '0;
    ill = 1'b0;
    case (op)
      4'b1000: d = a & b;
      4'b1110: d = a | b;
      4'b0110: d = a ^ b;
      4'b0001: d = ~(a | b);
      4'b1010: d = a;
`ifdef LOGIC_EXT_OPS_EN
      4'b0111: d = ~(a & b);
      4'b1001: d = ~(a ^ b);
      4'b1011: d = b;
      4'b0000: d = '0;
`endif
      default: begin
        d   = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, d};
  endfunction

  logic [WIDTH:0]   w_res_p0;
  logic [WIDTH-1:0] w_data_p0;
  logic             w_illegal_p0;
  logic             w_zero_p0;
  logic             w_accept_p0;
  logic             w_stage_free_p1;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic             r_zero_p1;
  logic             r_illegal_p1;

  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_zero;
  logic             r_skid_illegal;

  // Stage p0: evaluate the op at accept time so inputs need not be held.
  assign w_res_p0        = f_logic_op(in_a, in_b, in_ctrl);
  assign w_data_p0       = w_res_p0[WIDTH-1:0];
  assign w_illegal_p0    = w_res_p0[WIDTH];
  assign w_zero_p0       = (w_data_p0 == '0);

  assign in_ready        = ~r_skid_vld;
  assign w_accept_p0     = in_valid & ~r_skid_vld;
  assign w_stage_free_p1 = out_ready | ~r_vld_p1;

  // Stage p1: output register, refilled from the skid entry before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1       <= 1'b0;
      r_data_p1      <= '0;
      r_zero_p1      <= 1'b0;
      r_illegal_p1   <= 1'b0;
      r_skid_vld     <= 1'b0;
      r_skid_data    <= '0;
      r_skid_zero    <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else if (w_stage_free_p1) begin
      if (r_skid_vld) begin
        r_vld_p1     <= 1'b1;
        r_data_p1    <= r_skid_data;
        r_zero_p1    <= r_skid_zero;
        r_illegal_p1 <= r_skid_illegal;
        r_skid_vld   <= 1'b0;
      end else if (w_accept_p0) begin
        r_vld_p1     <= 1'b1;
        r_data_p1    <= w_data_p0;
        r_zero_p1    <= w_zero_p0;
        r_illegal_p1 <= w_illegal_p0;
      end else begin
        r_vld_p1     <= 1'b0;
      end
    end else if (w_accept_p0) begin
      r_skid_vld     <= 1'b1;
      r_skid_data    <= w_data_p0;
      r_skid_zero    <= w_zero_p0;
      r_skid_illegal <= w_illegal_p0;
    end
  end

  assign out_valid   = r_vld_p1;
  assign out_data    = r_data_p1;
  assign out_zero    = r_zero_p1;
  assign out_illegal = r_illegal_p1;

endmodule
